// File: rtl/fpunpack_if.sv
// fpunpack_norm_if: valid/ready bus bundle for the operand unpacker.
//   Input side : in_valid, in_ready, in_op[79:0], in_fmt[1:0], in_tag
//   Output side: out_valid, out_ready, out_A[80:0], out_class[4:0], out_snan, out_tag
//   slave  modport: the unpacker itself.
//   master modport: the producer/consumer driving the unpacker.
interface fpunpack_norm_if #(
    parameter int TAG_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [79:0]      in_op;
    logic [1:0]       in_fmt;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [80:0]      out_A;
    logic [4:0]       out_class;
    logic             out_snan;
    logic [TAG_W-1:0] out_tag;

    modport slave (
        input  in_valid, in_op, in_fmt, in_tag, out_ready,
        output in_ready, out_valid, out_A, out_class, out_snan, out_tag
    );

    modport master (
        output in_valid, in_op, in_fmt, in_tag, out_ready,
        input  in_ready, out_valid, out_A, out_class, out_snan, out_tag
    );
endinterface

// File: rtl/fpunpack_norm.sv
// fpunpack_norm: unpacks SNG/DBL/EXT operands into the internal 81-bit
// {sign, exp16 (bias 0x7FFF), mant64 (bit63 = integer bit)} format.
// Denormals are normalised over one or more NORM cycles, SHIFT_STEP bits
// at a time. The result sits in a one-entry holding register (HOLD).
// Ports:
//   clk  - clock
//   rst  - synchronous, active-high reset
//   bus  - fpunpack_norm_if.slave (in_* valid/ready, out_* valid/ready)
// Parameters:
//   TAG_W      - tag width, must match the interface instance
//   SHIFT_STEP - max left shift per NORM cycle (8, 16 or 32)
// Build option:
//   FPUNPK_DAZ_EN - when defined, denormals flush to signed zero
//                   (class denorm) and NORM is never entered.
module fpunpack_norm #(
    parameter int TAG_W      = 8,
    parameter int SHIFT_STEP = 16
) (
    input  logic              clk,
    input  logic              rst,
    fpunpack_norm_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, NORM, HOLD} state_t;

    localparam logic [4:0] C_NAN = 5'b10000, C_INF = 5'b01000, C_NORMAL = 5'b00100,
                           C_DENORM = 5'b00010, C_ZERO = 5'b00001;

    state_t           state_q, state_d;
    logic             sign_q, snan_q;
    logic [15:0]      exp_q;
    logic [63:0]      mant_q;
    logic [4:0]       cls_q;
    logic [TAG_W-1:0] tag_q;

    logic accept;
    assign bus.in_ready = (state_q == IDLE) || (state_q == HOLD && bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    // ---------------- input decode ----------------
    logic        f_sign, f_ext, e_zero, e_max, jbit, pay_nz;
    logic [15:0] f_exp, f_bias;
    logic [63:0] f_raw;
    logic        d_sign, d_snan, d_norm;
    logic [15:0] d_exp;
    logic [63:0] d_mant;
    logic [4:0]  d_cls;

    always_comb begin
        f_ext  = 1'b0;
        f_sign = 1'b0;
        f_exp  = '0;
        f_raw  = '0;
        f_bias = '0;
        e_zero = 1'b0;
        e_max  = 1'b0;
        case (bus.in_fmt)
            2'b00: begin
                f_sign = bus.in_op[31];
                f_exp  = {8'd0, bus.in_op[30:23]};
                e_zero = (bus.in_op[30:23] == '0);
                e_max  = &bus.in_op[30:23];
                f_raw  = {~e_zero, bus.in_op[22:0], 40'd0};
                f_bias = 16'h7F80;
            end
            2'b01: begin
                f_sign = bus.in_op[63];
                f_exp  = {5'd0, bus.in_op[62:52]};
                e_zero = (bus.in_op[62:52] == '0);
                e_max  = &bus.in_op[62:52];
                f_raw  = {~e_zero, bus.in_op[51:0], 11'd0};
                f_bias = 16'h7C00;
            end
            default: begin
                f_ext  = 1'b1;
                f_sign = bus.in_op[79];
                f_exp  = {1'b0, bus.in_op[78:64]};
                e_zero = (bus.in_op[78:64] == '0);
                e_max  = &bus.in_op[78:64];
                f_raw  = bus.in_op[63:0];
                f_bias = 16'h4000;
            end
        endcase
        // SNG/DBL have an implied J, so jbit can only be 1 at e==0 for EXT
        jbit   = f_raw[63];
        pay_nz = |f_raw[62:0];

        d_sign = f_sign;
        d_exp  = f_exp + f_bias;
        d_mant = f_raw;
        d_cls  = C_NORMAL;
        d_snan = 1'b0;
        d_norm = 1'b0;
        if (f_ext && !e_zero && !jbit) begin
            // unnormal, pseudo-NaN, pseudo-inf: canonical signalling invalid
            d_sign = 1'b1;
            d_exp  = 16'hFFFF;
            d_mant = 64'hC000_0000_0000_0000;
            d_cls  = C_NAN;
            d_snan = 1'b1;
        end else if (e_max) begin
            d_exp  = 16'hFFFF;
            d_mant = {1'b1, f_raw[62:0]};
            d_cls  = pay_nz ? C_NAN : C_INF;
            d_snan = pay_nz && !f_raw[62];
        end else if (e_zero) begin
            if (jbit) begin
                // EXT pseudo-denormal: already has J, just fix the exponent
                d_exp = f_bias + 16'd1;
            end else if (pay_nz) begin
                d_cls = C_DENORM;
`ifdef FPUNPK_DAZ_EN
                d_exp  = '0;
                d_mant = '0;
`else
                d_exp  = f_bias + 16'd1;
                d_norm = 1'b1;
`endif
            end else begin
                d_exp  = '0;
                d_mant = '0;
                d_cls  = C_ZERO;
            end
        end
    end

    // ---------------- normaliser step ----------------
    logic [SHIFT_STEP-1:0] top;
    logic                  top_zero, found;
    logic [5:0]            lz, shamt;

    assign top      = mant_q[63 -: SHIFT_STEP];
    assign top_zero = ~|top;

    always_comb begin
        lz    = '0;
        found = 1'b0;
        for (int i = 0; i < SHIFT_STEP; i++) begin
            if (!found && top[SHIFT_STEP-1-i]) begin
                lz    = 6'(i);
                found = 1'b1;
            end
        end
        shamt = top_zero ? 6'(SHIFT_STEP) : lz;
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = d_norm ? NORM : HOLD;
            NORM: if (!top_zero) state_d = HOLD;
            HOLD: if (bus.out_ready) state_d = accept ? (d_norm ? NORM : HOLD) : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- datapath / holding register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sign_q <= 1'b0;
            exp_q  <= '0;
            mant_q <= '0;
            cls_q  <= '0;
            snan_q <= 1'b0;
            tag_q  <= '0;
        end else if (accept) begin
            sign_q <= d_sign;
            exp_q  <= d_exp;
            mant_q <= d_mant;
            cls_q  <= d_cls;
            snan_q <= d_snan;
            tag_q  <= bus.in_tag;
        end else if (state_q == NORM) begin
            mant_q <= mant_q << shamt;
            exp_q  <= exp_q - {10'd0, shamt};
        end
    end

    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_A     = {sign_q, exp_q, mant_q};
    assign bus.out_class = cls_q;
    assign bus.out_snan  = snan_q;
    assign bus.out_tag   = tag_q;
endmodule
